md_unit: RTL
============

// Module: md_unit
// PURPOSE
//   Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
//   Sits beside alu: takes the same forwarded A/B operands and serves MULT,
//   MULTU, DIV, DIVU, MTHI and MTLO.
//   HI/LO are read back through the EX result mux for MFHI/MFLO.
//   Busy drives the hazard unit, which stalls IF/ID while any MD-class
//   instruction is in ID.
// PARAMETERS
//   MULT_LAT  5   cycles busy is held for MULT/MULTU (>=1)
//   DIV_LAT   10  cycles busy is held for DIV/DIVU (>=1)
// PORTS
//   clk     in   1   single clock; all state updates on the rising edge
//   reset   in   1   synchronous, active-low reset (0 = reset, sampled on clk)
//   start   in   1   qualifies MDOp this cycle (EX stage valid, not flushed)
//   MDOp    in   3   0 none,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 rsvd
//   A       in   32  rs operand (dividend / multiplicand / MTxx source)
//   B       in   32  rt operand (divisor / multiplier)
//   busy    out  1   operation in flight; registered
//   HI      out  32  HI register; registered
//   LO      out  32  LO register; registered
// BEHAVIOUR
//   Reset (reset==0 at the edge)
//     - busy=0, HI=0, LO=0, counter=0. Any in-flight op is aborted.
//   Accept
//     - Accept = start && !busy && MDOp in 1..4.
//     - At the accept edge, compute the result from A/B and hold it in
//       shadow regs {rhi,rlo}.
//     - Load counter with LAT-1; busy=1 from the next cycle.
//   Countdown
//     - While busy: counter decrements each edge.
//     - At the edge where counter==0: HI<=rhi, LO<=rlo, busy<=0.
//     - busy is therefore high for exactly LAT cycles.
//     - The new HI/LO are visible in the cycle after busy falls.
//   Visibility during busy
//     - HI/LO keep their old values until completion.
//   Arithmetic
//     - MULT: {HI,LO} = $signed(A) * $signed(B), 64-bit.
//     - MULTU: unsigned 64-bit product.
//     - DIV: LO = quotient truncated toward zero; HI = remainder, with the
//       sign of the dividend.
//     - DIVU: unsigned quotient and remainder.
//   Boundary cases
//     - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
//     - Divide by zero (B==0, DIV or DIVU): full busy period runs;
//       HI and LO are left unchanged.
//     - MTHI/MTLO with start && !busy: HI (or LO) <= A at that edge.
//       busy stays 0; the other register is untouched.
//     - start while busy: the op is ignored, including MTHI/MTLO.
//       The hazard unit guarantees this does not occur in legal flow.
//     - MDOp 0 or 7 with start: no effect.
//     - start with MDOp 1..4 in the same cycle that busy falls: busy is
//       still 1 that cycle, so the op is ignored.
// STRUCTURE
//   Shared package/header md_defs
//     - MDOp encodings: MD_NONE..MD_MTLO.
//     - Default latencies.
//     - Also used by the controller and the hazard unit.
//   One sub-module: md_core (combinational 64-bit mult/div datapath).
//     - Inputs: op, A, B.
//     - Outputs: {rhi,rlo}, divzero.
//   md_unit holds the counter, busy, shadow and HI/LO regs.
// TESTING
//   1. MULT A=0xFFFFFFFE(-2) B=3 -> busy high 5 cycles; then
//      HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//   2. MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> after 5 cycles
//      HI=0xFFFFFFFE, LO=0x00000001.
//   3. DIV A=-7 B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//      DIVU A=7 B=2 -> LO=3, HI=1.
//   4. DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
//      DIVU A=5 B=0 -> busy 10 cycles, HI/LO unchanged.
//   5. MTHI A=0x12345678 -> HI updates next cycle, busy stays 0.
//      MULT issued, then MTLO at cycle 2 of busy -> MTLO ignored;
//      the MULT result lands.
//   6. Start DIV, pull reset low at cycle 4 -> next edge busy=0, HI=LO=0.
//      Release reset, issue MULT 3*4 -> LO=12 after 5 cycles.

Source files
------------

// File: rtl/md_defs.sv
// Shared MD-class definitions: opcode encodings and default latencies.
// Used by md_unit, the controller and the hazard unit.
package md_defs;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational 64-bit multiply / 32-bit divide datapath for md_unit.
// Produces {rhi,rlo} for the selected op and flags divide-by-zero.
module md_core
    import md_defs::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] rhi,
    output logic [31:0] rlo,
    output logic        divzero
);

    logic signed [63:0] sa, sb, sprod;
    logic        [63:0] uprod;
    logic        [31:0] mag_a, mag_b, uq, ur, sq, sr;
    logic               sgn_a, sgn_b;

    assign sa    = {{32{a[31]}}, a};
    assign sb    = {{32{b[31]}}, b};
    assign sprod = sa * sb;
    assign uprod = {32'b0, a} * {32'b0, b};

    // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly
    // instead of hitting the overflow case of a native signed divide.
    assign sgn_a = a[31];
    assign sgn_b = b[31];
    assign mag_a = sgn_a ? (~a + 32'd1) : a;
    assign mag_b = sgn_b ? (~b + 32'd1) : b;

    always_comb begin
        uq = '0;
        ur = '0;
        sq = '0;
        sr = '0;
        if (b != 32'd0) begin
            uq = a / b;
            ur = a % b;
            sq = mag_a / mag_b;
            sr = mag_a % mag_b;
            if (sgn_a ^ sgn_b) sq = ~sq + 32'd1;
            if (sgn_a)         sr = ~sr + 32'd1;
        end
    end

    always_comb begin
        rhi     = '0;
        rlo     = '0;
        divzero = 1'b0;
        case (op)
            MD_MULT:  {rhi, rlo} = sprod;
            MD_MULTU: {rhi, rlo} = uprod;
            MD_DIV: begin
                rhi     = sr;
                rlo     = sq;
                divzero = (b == 32'd0);
            end
            MD_DIVU: begin
                rhi     = ur;
                rlo     = uq;
                divzero = (b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Result is latched at accept and committed to HI/LO when the countdown expires.
module md_unit
    import md_defs::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    logic [CW-1:0] cnt;
    logic [31:0]   rhi_q, rlo_q, rhi, rlo;
    logic          dz_q, divzero;

    md_core u_core (
        .op      (md_op_e'(MDOp)),
        .a       (A),
        .b       (B),
        .rhi     (rhi),
        .rlo     (rlo),
        .divzero (divzero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy  <= 1'b0;
            cnt   <= '0;
            HI    <= '0;
            LO    <= '0;
            rhi_q <= '0;
            rlo_q <= '0;
            dz_q  <= 1'b0;
        end else if (busy) begin
            // Any start seen while busy, MTHI/MTLO included, is dropped.
            if (cnt == '0) begin
                busy <= 1'b0;
                if (!dz_q) begin
                    HI <= rhi_q;
                    LO <= rlo_q;
                end
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else if (start) begin
            if (is_arith(MDOp)) begin
                rhi_q <= rhi;
                rlo_q <= rlo;
                dz_q  <= divzero;
                busy  <= 1'b1;
                cnt   <= (MDOp == MD_MULT || MDOp == MD_MULTU) ? CW'(MULT_LAT - 1)
                                                               : CW'(DIV_LAT - 1);
            end else if (MDOp == MD_MTHI) begin
                HI <= A;
            end else if (MDOp == MD_MTLO) begin
                LO <= A;
            end
        end
    end

endmodule
